// File: rtl/usb_pkg.sv
// usb_pkg
//   Definitions shared by the USB transmit-path blocks.
//   - stuff_state_t : state encoding of the bit stuffer
//   - USB_STUFF_RUN : length of the run of 1s that forces a stuffed 0
package usb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STUFF = 2'd2
  } stuff_state_t;

  localparam int USB_STUFF_RUN = 6;

endpackage

// File: rtl/usb_bit_stuffer.sv
// usb_bit_stuffer
//   Serial bit stuffer between the CRC-16 generator and the NRZI encoder.
//   Bits pass through with one cycle of latency. After MAX_ONES consecutive
//   1s a 0 is inserted. During the insertion, halt_tx holds the upstream
//   stage for one cycle so that no upstream bit is lost.
//
//   state | meaning
//   ------+------------------------------------------
//   IDLE  | tx_en low, nothing in flight
//   SHIFT | passing upstream bits through
//   STUFF | emitting the inserted 0 (data_in ignored)
//
// Ports
//   clk_c     in   single rising-edge clock
//   reset     in   synchronous active-high reset
//   tx_en     in   packet active, data_in valid
//   data_in   in   serial bit from the CRC stage
//   data_out  out  stuffed serial bit to the NRZI encoder
//   out_valid out  data_out carries a packet bit
//   halt_tx   out  hold request to the CRC stage
//   stuff_cnt out  stuffed bits in the current or last packet, saturating
module usb_bit_stuffer
  import usb_pkg::*;
#(
  parameter int MAX_ONES = USB_STUFF_RUN,
  parameter int CNT_W    = 8
) (
  input  logic             clk_c,
  input  logic             reset,
  input  logic             tx_en,
  input  logic             data_in,
  output logic             data_out,
  output logic             out_valid,
  output logic             halt_tx,
  output logic [CNT_W-1:0] stuff_cnt
);

  localparam logic [2:0] MAX_RUN = 3'(MAX_ONES);

  stuff_state_t state;
  logic [2:0]   ones_run;
  logic [2:0]   run_next;

  // ones_run never exceeds MAX_ONES (it is cleared by the stuffed bit),
  // so the 3-bit increment cannot wrap.
  always_comb begin
    run_next = data_in ? (ones_run + 3'd1) : 3'd0;
  end

  always_ff @(posedge clk_c) begin
    if (reset) begin
      state     <= IDLE;
      ones_run  <= '0;
      data_out  <= 1'b0;
      out_valid <= 1'b0;
      halt_tx   <= 1'b0;
      stuff_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          halt_tx <= 1'b0;
          if (tx_en) begin
            // First bit of a packet: the run restarts from this bit alone.
            state     <= SHIFT;
            data_out  <= data_in;
            out_valid <= 1'b1;
            ones_run  <= {2'b00, data_in};
            stuff_cnt <= '0;
          end else begin
            data_out  <= 1'b0;
            out_valid <= 1'b0;
            ones_run  <= '0;
          end
        end

        SHIFT: begin
          if (tx_en) begin
            data_out  <= data_in;
            out_valid <= 1'b1;
            ones_run  <= run_next;
            if (run_next == MAX_RUN) begin
              state   <= STUFF;
              halt_tx <= 1'b1;
            end else begin
              halt_tx <= 1'b0;
            end
          end else begin
            // stuff_cnt is left alone so it can be read after the packet.
            state     <= IDLE;
            data_out  <= 1'b0;
            out_valid <= 1'b0;
            halt_tx   <= 1'b0;
            ones_run  <= '0;
          end
        end

        STUFF: begin
          // Emitted even if tx_en has already fallen; the upstream bit
          // presented now is the held one and is sampled next edge.
          data_out  <= 1'b0;
          out_valid <= 1'b1;
          halt_tx   <= 1'b0;
          ones_run  <= '0;
          if (stuff_cnt != '1) begin
            stuff_cnt <= stuff_cnt + CNT_W'(1);
          end
          state <= tx_en ? SHIFT : IDLE;
        end

        default: begin
          state     <= IDLE;
          data_out  <= 1'b0;
          out_valid <= 1'b0;
          halt_tx   <= 1'b0;
          ones_run  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_bit_stuffer.sv
module tb_usb_bit_stuffer;

  localparam int MAX_ONES = 6;
  localparam int CNT_W    = 8;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk_c = 1'b0;
  logic             reset;
  logic             tx_en;
  logic             data_in;
  logic             data_out;
  logic             out_valid;
  logic             halt_tx;
  logic [CNT_W-1:0] stuff_cnt;

  usb_bit_stuffer #(.MAX_ONES(MAX_ONES), .CNT_W(CNT_W)) dut (
    .clk_c     (clk_c),
    .reset     (reset),
    .tx_en     (tx_en),
    .data_in   (data_in),
    .data_out  (data_out),
    .out_valid (out_valid),
    .halt_tx   (halt_tx),
    .stuff_cnt (stuff_cnt)
  );

  always #5 clk_c = ~clk_c;

  int tests = 0;
  int fails = 0;

  bit pkt[$];
  bit outq[$];
  bit expq[$];
  int halt_cyc[$];
  int exp_cnt;
  bit first_ok;
  bit halt_bad;
  bit timed_out;

  // Reference: insert a 0 after every MAX_ONES consecutive 1s; the
  // inserted 0 restarts the run.
  function automatic void build_ref();
    int run = 0;
    int raw = 0;
    expq.delete();
    foreach (pkt[i]) begin
      expq.push_back(pkt[i]);
      run = pkt[i] ? run + 1 : 0;
      if (run == MAX_ONES) begin
        expq.push_back(1'b0);
        raw++;
        run = 0;
      end
    end
    exp_cnt = (raw > CNT_MAX) ? CNT_MAX : raw;
  endfunction

  function automatic int diff_pos();
    if (outq.size() != expq.size()) return -2;
    foreach (expq[i]) if (outq[i] !== expq[i]) return i;
    return -1;
  endfunction

  // Upstream model: presents pkt bit by bit, advancing only at edges where
  // halt_tx was low; then drops tx_en for a few cycles.
  task automatic run_packet();
    int idx = 0;
    int cyc = 0;
    int tail = 0;
    int limit;
    bit h, en, prev_h;
    limit = pkt.size() * 2 + 50;
    outq.delete();
    halt_cyc.delete();
    first_ok = 1'b0;
    halt_bad = 1'b0;
    timed_out = 1'b0;
    prev_h = 1'b0;
    while (tail < 3 && cyc < limit) begin
      @(negedge clk_c);
      h = halt_tx;
      if (idx < pkt.size()) begin
        tx_en = 1'b1;
        data_in = pkt[idx];
      end else begin
        tx_en = 1'b0;
        data_in = 1'($urandom);
        tail++;
      end
      en = tx_en;
      @(posedge clk_c);
      #1;
      cyc++;
      if (en && !h) begin
        if (idx == 0) first_ok = (out_valid === 1'b1) && (data_out === pkt[0]);
        idx++;
      end
      if (out_valid === 1'b1) outq.push_back(data_out);
      if (halt_tx === 1'b1) begin
        halt_cyc.push_back(cyc);
        if (h || out_valid !== 1'b1) halt_bad = 1'b1;
      end
      prev_h = h;
    end
    if (cyc >= limit) timed_out = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tx_en = 1'b1;
    data_in = 1'b1;
    repeat (3) @(posedge clk_c);
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++; if (data_out !== 1'b0) begin fails++; $display("FAIL reset_data_out got %b want 0", data_out); end
    tests++; if (halt_tx !== 1'b0) begin fails++; $display("FAIL reset_halt got %b want 0", halt_tx); end
    tests++; if (stuff_cnt !== '0) begin fails++; $display("FAIL reset_cnt got %0d want 0", stuff_cnt); end
    @(negedge clk_c);
    tx_en = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk_c);
  endtask

  task automatic test_alternating();
    int d;
    pkt.delete();
    for (int i = 0; i < 16; i++) pkt.push_back(1'((i + 1) % 2));
    build_ref();
    run_packet();
    d = diff_pos();
    tests++; if (timed_out) begin fails++; $display("FAIL alt_timeout"); end
    tests++; if (!first_ok) begin fails++; $display("FAIL alt_latency first bit got %b want %b", outq.size() > 0 ? outq[0] : 1'bx, pkt[0]); end
    tests++; if (d != -1) begin fails++; $display("FAIL alt_stream pos %0d got_len %0d want_len %0d", d, outq.size(), expq.size()); end
    tests++; if (halt_cyc.size() != 0) begin fails++; $display("FAIL alt_halt got %0d halts want 0", halt_cyc.size()); end
    tests++; if (stuff_cnt !== 8'd0) begin fails++; $display("FAIL alt_cnt got %0d want 0", stuff_cnt); end
  endtask

  task automatic test_twelve_ones();
    int d;
    pkt.delete();
    repeat (12) pkt.push_back(1'b1);
    build_ref();
    run_packet();
    d = diff_pos();
    tests++; if (d != -1 || outq.size() != 14) begin fails++; $display("FAIL twelve_stream pos %0d got_len %0d want_len 14", d, outq.size()); end
    tests++; if (halt_cyc.size() != 2) begin fails++; $display("FAIL twelve_halt_count got %0d want 2", halt_cyc.size()); end
    else begin
      tests++; if (halt_cyc[1] - halt_cyc[0] != 7) begin fails++; $display("FAIL twelve_halt_gap got %0d want 7", halt_cyc[1] - halt_cyc[0]); end
    end
    tests++; if (stuff_cnt !== 8'd2) begin fails++; $display("FAIL twelve_cnt got %0d want 2", stuff_cnt); end
    tests++; if (halt_bad) begin fails++; $display("FAIL twelve_halt_shape got bad want clean"); end
  endtask

  task automatic test_near_run();
    int d;
    bit pat[13] = '{1,1,1,1,1,0,1,1,1,1,1,1,0};
    pkt.delete();
    foreach (pat[i]) pkt.push_back(pat[i]);
    build_ref();
    run_packet();
    d = diff_pos();
    tests++; if (d != -1 || outq.size() != 14) begin fails++; $display("FAIL near_stream pos %0d got_len %0d want_len 14", d, outq.size()); end
    tests++; if (stuff_cnt !== 8'd1) begin fails++; $display("FAIL near_cnt got %0d want 1", stuff_cnt); end
  endtask

  task automatic test_stuff_at_end();
    int d;
    pkt.delete();
    repeat (6) pkt.push_back(1'b1);
    build_ref();
    run_packet();
    d = diff_pos();
    tests++; if (d != -1 || outq.size() != 7) begin fails++; $display("FAIL end_stream pos %0d got_len %0d want_len 7", d, outq.size()); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL end_valid got %b want 0", out_valid); end
    tests++; if (stuff_cnt !== 8'd1) begin fails++; $display("FAIL end_cnt got %0d want 1", stuff_cnt); end
  endtask

  task automatic test_reset_in_stuff();
    int d;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_c);
      tx_en = 1'b1;
      data_in = 1'b1;
      @(posedge clk_c);
      #1;
    end
    tests++; if (halt_tx !== 1'b1) begin fails++; $display("FAIL rst_pre_halt got %b want 1", halt_tx); end
    @(negedge clk_c);
    reset = 1'b1;
    @(posedge clk_c);
    #1;
    tests++; if (halt_tx !== 1'b0) begin fails++; $display("FAIL rst_mid_halt got %b want 0", halt_tx); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_valid got %b want 0", out_valid); end
    tests++; if (stuff_cnt !== '0) begin fails++; $display("FAIL rst_mid_cnt got %0d want 0", stuff_cnt); end
    @(negedge clk_c);
    reset = 1'b0;
    tx_en = 1'b0;
    @(posedge clk_c);
    #1;
    tests++; if (halt_tx !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL rst_after got halt %b valid %b want 0 0", halt_tx, out_valid); end
    pkt.delete();
    repeat (5) pkt.push_back(1'b1);
    pkt.push_back(1'b0);
    repeat (6) pkt.push_back(1'b1);
    build_ref();
    run_packet();
    d = diff_pos();
    tests++; if (d != -1) begin fails++; $display("FAIL rst_next_stream pos %0d got_len %0d want_len %0d", d, outq.size(), expq.size()); end
    tests++; if (stuff_cnt !== 8'(exp_cnt)) begin fails++; $display("FAIL rst_next_cnt got %0d want %0d", stuff_cnt, exp_cnt); end
  endtask

  task automatic test_random();
    int d;
    for (int p = 0; p < 10; p++) begin
      pkt.delete();
      repeat ($urandom_range(1, 60)) pkt.push_back(($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0);
      build_ref();
      run_packet();
      d = diff_pos();
      tests++; if (timed_out || d != -1) begin fails++; $display("FAIL rand%0d_stream pos %0d got_len %0d want_len %0d", p, d, outq.size(), expq.size()); end
      tests++; if (stuff_cnt !== 8'(exp_cnt)) begin fails++; $display("FAIL rand%0d_cnt got %0d want %0d", p, stuff_cnt, exp_cnt); end
      tests++; if (halt_bad || halt_cyc.size() != exp_cnt) begin fails++; $display("FAIL rand%0d_halt got %0d halts want %0d", p, halt_cyc.size(), exp_cnt); end
    end
  endtask

  task automatic test_saturation();
    int d;
    int bad_gap = 0;
    pkt.delete();
    repeat (1600) pkt.push_back(1'b1);
    build_ref();
    run_packet();
    d = diff_pos();
    for (int i = 1; i < halt_cyc.size(); i++)
      if (halt_cyc[i] - halt_cyc[i-1] != MAX_ONES + 1) bad_gap++;
    tests++; if (timed_out || d != -1) begin fails++; $display("FAIL sat_stream pos %0d got_len %0d want_len %0d", d, outq.size(), expq.size()); end
    tests++; if (stuff_cnt !== 8'd255) begin fails++; $display("FAIL sat_cnt got %0d want 255", stuff_cnt); end
    tests++; if (bad_gap != 0 || halt_cyc.size() != 1600 / MAX_ONES) begin fails++; $display("FAIL sat_cadence got %0d bad gaps %0d halts want 0 and %0d", bad_gap, halt_cyc.size(), 1600 / MAX_ONES); end
  endtask

  initial begin
    reset = 1'b1;
    tx_en = 1'b0;
    data_in = 1'b0;
    test_reset();
    test_alternating();
    test_twelve_ones();
    test_near_run();
    test_stuff_at_end();
    test_reset_in_stuff();
    test_random();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
